// File: rtl/pulse_burst_tx.sv
// ----------------------------------------------------------------------------
// pulse_burst_tx
//
// Transmit-side stimulus generator for the delay line. After a start/ready
// handshake it emits `count` rectangular pulses on tx_out. Each pulse is
// `width` cycles at the active level followed by `period - width` cycles at
// IDLE_LEVEL. Every output is registered.
//
// Optional build macro: PULSE_BURST_TX_RTT_EN
//   Adds a round-trip-time measurement of the returned signal rx_in.
//
// Parameters
//   PERIOD_W   width of the period / width fields and of the phase counter
//   COUNT_W    width of the pulse count field
//   IDLE_LEVEL level of tx_out outside the pulse high phase
//
// Ports
//   clk        system clock (PLL output)
//   n_reset    asynchronous active-low reset
//   start      burst request, accepted when start && ready && !abort
//   abort      terminate a running burst at the next edge
//   period     pulse period in cycles, sampled on accept
//   width      active-phase length in cycles, sampled on accept
//   count      number of pulses, sampled on accept
//   ready      high while idle
//   busy       high while a burst is running
//   done       one-cycle pulse when a burst completes or a config is rejected
//   err        one-cycle pulse when an accepted config is invalid
//   tx_out     registered pulse output
//   tx_en      output-driver enable, follows busy
//   rx_in      (RTT build) returned delayed signal, asynchronous
//   rtt        (RTT build) measured round trip in cycles, incl. 2 sync cycles
//   rtt_valid  (RTT build) one-cycle pulse when rtt is updated
// ----------------------------------------------------------------------------
module pulse_burst_tx #(
    parameter int   PERIOD_W   = 16,
    parameter int   COUNT_W    = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                start,
    input  logic                abort,
    input  logic [PERIOD_W-1:0] period,
    input  logic [PERIOD_W-1:0] width,
    input  logic [COUNT_W-1:0]  count,
`ifdef PULSE_BURST_TX_RTT_EN
    input  logic                rx_in,
    output logic [PERIOD_W-1:0] rtt,
    output logic                rtt_valid,
`endif
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                tx_out,
    output logic                tx_en
);

    localparam logic                ACTIVE = ~IDLE_LEVEL;
    localparam logic [PERIOD_W-1:0] ONE_P  = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0]  ONE_C  = {{(COUNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

    state_t              state_q;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] width_q;
    logic [PERIOD_W-1:0] phase_q;
    logic [COUNT_W-1:0]  pulses_q;
    logic                ready_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic                tx_q;
    logic                en_q;

    logic                accept;
    logic                cfg_ok;
    logic                phase_end;
    logic                last_pulse;
    logic [PERIOD_W-1:0] low_m1;

    // ready_q is only ever high in S_IDLE, so it doubles as the idle qualifier.
    assign accept     = start & ready_q & ~abort;
    assign cfg_ok     = (count != '0) && (width != '0) && (width < period);
    assign phase_end  = (phase_q == '0);
    assign last_pulse = (pulses_q <= ONE_C);
    // Low phase length minus one. Cannot underflow: width < period.
    assign low_m1     = period_q - width_q - ONE_P;

    // The phase counter is loaded with (length - 1) and the phase ends on the
    // edge where it reads zero, so each phase lasts exactly `length` cycles.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q  <= S_IDLE;
            period_q <= '0;
            width_q  <= '0;
            phase_q  <= '0;
            pulses_q <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            tx_q     <= IDLE_LEVEL;
            en_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (state_q != S_IDLE && abort) begin
                state_q <= S_IDLE;
                ready_q <= 1'b1;
                busy_q  <= 1'b0;
                en_q    <= 1'b0;
                tx_q    <= IDLE_LEVEL;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (accept) begin
                            period_q <= period;
                            width_q  <= width;
                            pulses_q <= count;
                            if (cfg_ok) begin
                                state_q <= S_HIGH;
                                phase_q <= width - ONE_P;
                                ready_q <= 1'b0;
                                busy_q  <= 1'b1;
                                en_q    <= 1'b1;
                                tx_q    <= ACTIVE;
                            end else begin
                                err_q  <= 1'b1;
                                done_q <= 1'b1;
                            end
                        end
                    end
                    S_HIGH: begin
                        if (phase_end) begin
                            state_q <= S_LOW;
                            phase_q <= low_m1;
                            tx_q    <= IDLE_LEVEL;
                        end else begin
                            phase_q <= phase_q - ONE_P;
                        end
                    end
                    S_LOW: begin
                        if (phase_end) begin
                            if (last_pulse) begin
                                state_q <= S_IDLE;
                                ready_q <= 1'b1;
                                busy_q  <= 1'b0;
                                en_q    <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q  <= S_HIGH;
                                phase_q  <= width_q - ONE_P;
                                pulses_q <= pulses_q - ONE_C;
                                tx_q     <= ACTIVE;
                            end
                        end else begin
                            phase_q <= phase_q - ONE_P;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign ready  = ready_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign tx_out = tx_q;
    assign tx_en  = en_q;

`ifdef PULSE_BURST_TX_RTT_EN
    logic                rx_s1_q;
    logic                rx_s2_q;
    logic                rx_s3_q;
    logic                meas_q;
    logic [PERIOD_W-1:0] rtt_cnt_q;
    logic [PERIOD_W-1:0] rtt_q;
    logic                rtt_valid_q;
    logic                burst_start;
    logic                burst_end;
    logic                rx_rise;

    assign burst_start = accept & cfg_ok;
    assign burst_end   = (state_q != S_IDLE) &&
                         (abort || (state_q == S_LOW && phase_end && last_pulse));
    // rx_s3_q is only a history bit for edge detection, not a third sync stage.
    assign rx_rise     = (rx_s2_q == ACTIVE) && (rx_s3_q != ACTIVE);

    // The counter clears at the edge that launches the first active tx_out
    // level and then counts every edge until the synchronised rx edge is seen,
    // so the result includes the two synchroniser cycles.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rx_s1_q     <= IDLE_LEVEL;
            rx_s2_q     <= IDLE_LEVEL;
            rx_s3_q     <= IDLE_LEVEL;
            meas_q      <= 1'b0;
            rtt_cnt_q   <= '0;
            rtt_q       <= '0;
            rtt_valid_q <= 1'b0;
        end else begin
            rx_s1_q     <= rx_in;
            rx_s2_q     <= rx_s1_q;
            rx_s3_q     <= rx_s2_q;
            rtt_valid_q <= 1'b0;
            if (burst_start) begin
                meas_q    <= 1'b1;
                rtt_cnt_q <= '0;
            end else if (meas_q) begin
                if (rx_rise) begin
                    rtt_q       <= rtt_cnt_q;
                    rtt_valid_q <= 1'b1;
                    meas_q      <= 1'b0;
                end else if (burst_end) begin
                    rtt_q       <= '1;
                    rtt_valid_q <= 1'b1;
                    meas_q      <= 1'b0;
                end else if (rtt_cnt_q != '1) begin
                    rtt_cnt_q <= rtt_cnt_q + ONE_P;
                end
            end
        end
    end

    assign rtt       = rtt_q;
    assign rtt_valid = rtt_valid_q;
`endif

endmodule

// File: tb/tb_pulse_burst_tx.sv
module tb_pulse_burst_tx;

    localparam int   PERIOD_W = 16;
    localparam int   COUNT_W  = 8;
    localparam logic IDLE     = 1'b0;
    localparam logic ACT      = ~IDLE;

    logic                clk;
    logic                n_reset;
    logic                start;
    logic                abort;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] width;
    logic [COUNT_W-1:0]  count;
    logic                ready;
    logic                busy;
    logic                done;
    logic                err;
    logic                tx_out;
    logic                tx_en;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef PULSE_BURST_TX_RTT_EN
    localparam int DLY = 5;
    logic                rx_in;
    logic [PERIOD_W-1:0] rtt;
    logic                rtt_valid;
    logic [DLY-1:0]      dly;
    logic                rx_mode;
    int                  rv_cnt;
    logic [PERIOD_W-1:0] rv_last;

    // External delay line model: tx_out returns DLY cycles later.
    always @(posedge clk) dly <= {dly[DLY-2:0], tx_out};
    assign rx_in = rx_mode ? dly[DLY-1] : IDLE;

    always @(negedge clk) begin
        if (rtt_valid) begin
            rv_cnt  = rv_cnt + 1;
            rv_last = rtt;
        end
    end
`endif

    pulse_burst_tx #(
        .PERIOD_W  (PERIOD_W),
        .COUNT_W   (COUNT_W),
        .IDLE_LEVEL(IDLE)
    ) dut (
        .clk    (clk),
        .n_reset(n_reset),
        .start  (start),
        .abort  (abort),
        .period (period),
        .width  (width),
        .count  (count),
`ifdef PULSE_BURST_TX_RTT_EN
        .rx_in    (rx_in),
        .rtt      (rtt),
        .rtt_valid(rtt_valid),
`endif
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .tx_out (tx_out),
        .tx_en  (tx_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed status vector: {ready, busy, done, err, tx_out, tx_en}
    logic [5:0] obs;
    assign obs = {ready, busy, done, err, tx_out, tx_en};

    localparam logic [5:0] IDLE_VEC = {1'b1, 1'b0, 1'b0, 1'b0, IDLE, 1'b0};
    localparam logic [5:0] ERR_VEC  = {1'b1, 1'b0, 1'b1, 1'b1, IDLE, 1'b0};

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: k = number of edges after the accept edge at which outputs
    // are sampled (k = 0 is the cycle right after accept).
    function automatic logic [5:0] burst_vec(int p, int w, int c, int k);
        if (k < c * p)
            return {1'b0, 1'b1, 1'b0, 1'b0, ((k % p) < w) ? ACT : IDLE, 1'b1};
        else
            return {1'b1, 1'b0, 1'b1, 1'b0, IDLE, 1'b0};
    endfunction

    task automatic launch(input int p, input int w, input int c);
        period = PERIOD_W'(p);
        width  = PERIOD_W'(w);
        count  = COUNT_W'(c);
        start  = 1'b1;
        tick();
    endtask

    // Checks samples k = 0 .. kmax of a burst launched by launch().
    task automatic follow(input string tag, input int p, input int w, input int c,
                          input bit hold, input int kmax);
        for (int k = 0; k <= kmax; k++) begin
            if (k > 0) tick();
            chk(tag, {26'd0, obs}, {26'd0, burst_vec(p, w, c, k)});
            if (k == 0 && !hold) begin
                start  = 1'b0;
                period = PERIOD_W'($urandom);
                width  = PERIOD_W'($urandom);
                count  = COUNT_W'($urandom);
            end
        end
    endtask

    initial begin
        int p, w, c, kind;
        n_reset = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        period  = '0;
        width   = '0;
        count   = '0;
`ifdef PULSE_BURST_TX_RTT_EN
        rx_mode = 1'b0;
        rv_cnt  = 0;
        rv_last = '0;
`endif
        // Reset state
        tick();
        tick();
        chk("reset_vec", {26'd0, obs}, {26'd0, IDLE_VEC});
`ifdef PULSE_BURST_TX_RTT_EN
        chk("reset_rtt", {16'd0, rtt, 15'd0, rtt_valid}, 32'd0);
`endif
        n_reset = 1'b1;

        // Idle with no start for 100 cycles
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("idle_hold", {26'd0, obs}, {26'd0, IDLE_VEC});
        end

        // Main directed burst: 4 pulses, high 3 / low 7
        launch(10, 3, 4);
        follow("burst_10_3_4", 10, 3, 4, 1'b0, 40);
        tick();
        chk("after_done", {26'd0, obs}, {26'd0, IDLE_VEC});

        // Invalid configurations: count=0, then width=period
        launch(10, 3, 0);
        start = 1'b0;
        chk("err_count0", {26'd0, obs}, {26'd0, ERR_VEC});
        tick();
        chk("err_count0_end", {26'd0, obs}, {26'd0, IDLE_VEC});
        launch(10, 10, 2);
        start = 1'b0;
        chk("err_w_eq_p", {26'd0, obs}, {26'd0, ERR_VEC});
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("err_w_eq_p_idle", {26'd0, obs}, {26'd0, IDLE_VEC});
        end

        // Random invalid configurations
        for (int i = 0; i < 6; i++) begin
            kind = int'($urandom_range(0, 2));
            p = int'($urandom_range(1, 12));
            w = int'($urandom_range(1, 12));
            c = int'($urandom_range(1, 5));
            if (kind == 0) c = 0;
            else if (kind == 1) w = 0;
            else w = p + int'($urandom_range(0, 4));
            launch(p, w, c);
            start = 1'b0;
            chk("err_rand", {26'd0, obs}, {26'd0, ERR_VEC});
            tick();
            chk("err_rand_end", {26'd0, obs}, {26'd0, IDLE_VEC});
        end

        // One-cycle low phase
        launch(5, 4, 2);
        follow("burst_5_4_2", 5, 4, 2, 1'b0, 10);
        tick();

        // Random valid bursts
        for (int i = 0; i < 8; i++) begin
            p = int'($urandom_range(2, 12));
            w = int'($urandom_range(1, p - 1));
            c = int'($urandom_range(1, 4));
            launch(p, w, c);
            follow("burst_rand", p, w, c, 1'b0, c * p);
            tick();
            chk("burst_rand_idle", {26'd0, obs}, {26'd0, IDLE_VEC});
        end

        // start held high re-triggers right after returning to idle
        launch(3, 1, 2);
        follow("hold_first", 3, 1, 2, 1'b1, 6);
        tick();
        follow("hold_second", 3, 1, 2, 1'b0, 6);
        tick();

        // Abort at cycle 15 of a long burst
        launch(8, 4, 5);
        follow("abort_pre", 8, 4, 5, 1'b0, 14);
        abort = 1'b1;
        tick();
        chk("abort_idle", {26'd0, obs}, {26'd0, IDLE_VEC});
        abort = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("abort_no_done", {26'd0, obs}, {26'd0, IDLE_VEC});
        end

        // start together with abort in idle is not accepted
        period = 16'd6;
        width  = 16'd2;
        count  = 8'd2;
        start  = 1'b1;
        abort  = 1'b1;
        tick();
        chk("start_abort", {26'd0, obs}, {26'd0, IDLE_VEC});
        start = 1'b0;
        abort = 1'b0;
        tick();
        chk("start_abort_after", {26'd0, obs}, {26'd0, IDLE_VEC});

        // Asynchronous reset during the high phase
        launch(10, 5, 2);
        follow("rst_pre", 10, 5, 2, 1'b0, 2);
        #2;
        n_reset = 1'b0;
        #1;
        chk("async_reset", {26'd0, obs}, {26'd0, IDLE_VEC});
        tick();
        n_reset = 1'b1;
        tick();
        chk("post_reset_idle", {26'd0, obs}, {26'd0, IDLE_VEC});

        // clk/2 square wave
        launch(2, 1, 3);
        follow("sq_2_1_3", 2, 1, 3, 1'b0, 6);
        tick();

`ifdef PULSE_BURST_TX_RTT_EN
        // Loopback through the external delay
        rx_mode = 1'b1;
        for (int i = 0; i < DLY + 3; i++) tick();
        rv_cnt = 0;
        launch(20, 5, 2);
        follow("rtt_burst", 20, 5, 2, 1'b0, 40);
        tick();
        chk("rtt_valid_once", rv_cnt, 1);
        chk("rtt_loop", {16'd0, rv_last}, DLY + 2);

        // rx tied to idle: timeout value at burst end
        rx_mode = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rv_cnt = 0;
        launch(10, 3, 1);
        follow("rtt_tied", 10, 3, 1, 1'b0, 10);
        tick();
        chk("rtt_tied_once", rv_cnt, 1);
        chk("rtt_tied_val", {16'd0, rv_last}, 32'h0000_FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
